// File: rtl/alu_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issue_if
// Description : Command, ALU-drive and response bundle for alu_cmd_issue.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_cmd_issue_if #(
    parameter int DW = 16,
    parameter int RW = 32
);
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [2:0]    cmd_opcode;
    logic          cmd_mode;

    // ALU drive and return
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_opcode;
    logic          alu_mode;
    logic [RW-1:0] alu_result;
    logic [4:0]    alu_flags;

    // response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_result;
    logic [4:0]    rsp_flags;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_mode,
        input  alu_result, alu_flags, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode, alu_mode,
        output rsp_valid, rsp_result, rsp_flags
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_mode,
        output alu_result, alu_flags, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode, alu_mode,
        input  rsp_valid, rsp_result, rsp_flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issue
// Description : Buffers ALU commands in a FIFO, issues them to the ALU from
//               registers and captures result/flags into a response channel.
// Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int RW    = 32
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    alu_cmd_issue_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 2*DW + 4;

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;

    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [2:0]    r_alu_opcode;
    logic          r_alu_mode;

    logic          r_rsp_valid;
    logic [RW-1:0] r_rsp_result;
    logic [4:0]    r_rsp_flags;

    logic          w_cmd_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_has_cmd;
    logic [EW-1:0] w_head;

    // Ready looks only at registered occupancy: no bypass when full.
    assign w_cmd_ready = !rst && (r_count < c_depth);
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_has_cmd   = (r_count != '0);
    assign w_head      = r_mem[r_rptr];

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            c_st_idle: w_pop = w_has_cmd;
            c_st_resp: w_pop = w_has_cmd && bus.rsp_ready;
            default:   w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.cmd_mode, bus.cmd_opcode, bus.cmd_b, bus.cmd_a};
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_alu_mode   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_pop) begin
                {r_alu_mode, r_alu_opcode, r_alu_b, r_alu_a} <= w_head;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_has_cmd) begin
                        r_state <= c_st_exec;
                    end
                end
                // One settle cycle for the combinational ALU, then capture.
                c_st_exec: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_flags  <= bus.alu_flags;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= c_st_resp;
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_has_cmd ? c_st_exec : c_st_idle;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_mode   = r_alu_mode;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign count          = r_count;
    assign busy           = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Command issue and result capture stage wrapped around the combinational ALU.
- Accepts ALU commands (operands, opcode, mode) over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU input bus from registers, captures the 32-bit result and five flags one cycle later, and presents them on a valid/ready response interface.

Parameters:
- DEPTH, 4, command FIFO depth; power of two, minimum 2.
- DW, 16, operand width (matches ALU a/b).
- RW, 32, result width (matches ALU output).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_a  input  DW  operand A.
- cmd_b  input  DW  operand B.
- cmd_opcode  input  3  ALU opcode.
- cmd_mode  input  1  1 = arithmetic, 0 = logic.
- alu_a  output  DW  registered operand A to ALU.
- alu_b  output  DW  registered operand B to ALU.
- alu_opcode  output  3  registered opcode to ALU.
- alu_mode  output  1  registered mode to ALU.
- alu_result  input  RW  ALU result.
- alu_flags  input  5  ALU flags {za,zb,eq,gt,lt}.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  RW  captured result.
- rsp_flags  output  5  captured flags {za,zb,eq,gt,lt}.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count go to 0.
  - FSM goes to IDLE.
  - alu_a/alu_b/alu_opcode/alu_mode, rsp_result and rsp_flags go to 0.
  - rsp_valid and busy go to 0.
  - cmd_ready is forced 0 while rst is high.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !rst && (count < DEPTH); it depends only on registered count, with no same-cycle bypass when full.
  - Pop is issued by the FSM only.
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
  - IDLE:
    - If count > 0: pop the head into the alu_* registers and go to EXEC.
    - Otherwise stay in IDLE.
  - EXEC:
    - Exactly one cycle, allowing the ALU combinational path to settle.
    - At the next edge, register alu_result into rsp_result and alu_flags into rsp_flags, set rsp_valid = 1, go to RESP.
  - RESP:
    - rsp_valid, rsp_result and rsp_flags are held stable until rsp_valid && rsp_ready.
    - On that handshake edge, rsp_valid goes to 0.
    - If count > 0 at that edge, pop the next command into alu_* and go to EXEC; otherwise go to IDLE.
- alu_* registers retain the last issued command between operations; they are not cleared on idle.
- Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE is issued at edge N+1 and has rsp_valid high after edge N+2.
- Throughput: with rsp_ready tied high, one response every 2 cycles; rsp_valid toggles high/low.
- Capacity: with rsp_ready low, up to DEPTH+1 commands are accepted before cmd_ready falls (DEPTH in FIFO plus one held in the response register).
- Flags are passed through exactly as the ALU drives them; no recomputation.
- Result width is not checked; the stage does not modify result values.
- Reset asserted mid-operation discards all FIFO contents and any in-flight or pending response; no partial response appears after reset is released.

Test Plan:
- Bench instantiates alu_cmd_issue wired to the ALU module.
- Add: a=3, b=5, opcode=000, mode=1, rsp_ready=1 -> rsp_valid two edges after acceptance, rsp_result=32'h00000008, rsp_flags=5'b00001.
- Multiply then logic AND, back-to-back:
  - (a=16'h00FF, b=16'h0100, op 001, mode 1) -> 32'h0000FF00.
  - (a=16'hF0F0, b=16'hFF00, op 000, mode 0) -> 32'h0000F000.
  - Responses arrive in order, 2 cycles apart.
- Backpressure fill: rsp_ready=0, cmd_valid held with 8 commands -> exactly 5 accepted, cmd_ready=0, count=4, and the first response is held stable for 20 cycles. Raising rsp_ready then drains all 5 in order; count returns to 0, busy to 0.
- Zero/equal flags: a=0, b=0, op 000, mode 1 -> rsp_result=0, rsp_flags=5'b11100.
- Reset mid-op: assert rst during EXEC with count=2 -> rsp_valid=0, count=0, busy=0 immediately. After release, a new command a=7, b=2, op 010, mode 1 -> rsp_result=32'h00000005.
- Simultaneous push/pop at count=DEPTH-1 while in RESP with rsp_ready=1 -> count unchanged, no command lost or duplicated (checked by an ordered scoreboard).
